tt_mult_ctrl: RTL and testbench
===============================

# tt_mult_ctrl

Sequencer for the ternary matrix-vector multiply core (16-element int8 input vector, 16x8 ternary weight matrix, 8 int8 outputs). Loads the 256-bit weight image byte-serially, buffers input vectors in a two-bank ping-pong store, and drives the core's enable and vector-pair inputs with exact 8-cycle phasing. Captures the core's serial column outputs into a valid-tagged stream. Sits between the tile's pin interface and the multiply core.

## Interface
- IN_LEN, 16, input vector length (elements)
- OUT_LEN, 8, output vector length (columns)
- BIT_WIDTH, 8, element width
- CFG_W, 8, weight-load beat width (4 ternary codes per beat)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_valid  in  1  weight beat valid
- cfg_data  in  CFG_W  weight beat; beat n writes W[n*8 +: 8]
- cfg_ready  out  1  weight beat accepted when cfg_valid && cfg_ready
- in_valid  in  1  input pair valid
- in_data  in  2*BIT_WIDTH  [15:8] = element 2k, [7:0] = element 2k+1
- in_ready  out  1  a buffer bank is free or filling
- out_valid  out  1  out_data holds a column result
- out_data  out  BIT_WIDTH  column result, two's complement, mod 2^8
- out_last  out  1  marks column 7
- w_loaded  out  1  full 32-beat weight image present
- busy  out  1  core running (FEED or DRAIN)
- core_en  out  1  core enable; low resets the core's row counter
- core_vec  out  2*BIT_WIDTH  pair presented to the core
- core_w  out  2*IN_LEN*OUT_LEN  weight image; code for (row r, col c) at [2*(r*8+c) +: 2]: 01 = +1, 1x = -1, 00 = 0
- core_vec_out  in  BIT_WIDTH  core serial result

## Operation
- Weight load: beats accepted only in IDLE or LOAD_W; first beat clears w_loaded and enters LOAD_W; 5-bit beat counter; 32nd beat sets w_loaded, returns to IDLE. cfg_ready = 0 while busy.
- Input buffer: two banks × 8 pairs; fill pointer 0..7 per bank; bank becomes full on 8th pair. in_ready = 1 when the fill bank is not full. Fill accepted in any state, including during a run.
- States: IDLE, LOAD_W, FEED, DRAIN.
- IDLE → FEED when w_loaded && a bank is full && no weight load in progress (beat counter = 0).
- FEED: core_en = 1, core_vec = bank[run][phase], phase 0..7. At phase 7: release the bank; if the other bank is full, stay in FEED with phase 0 on the other bank (back-to-back); otherwise go to DRAIN.
- DRAIN: core_en = 1, core_vec = 0, d = 0..7, then go to IDLE (core_en = 0 for at least one cycle). A bank that fills during DRAIN waits for IDLE.
- Capture: column k of a vector appears on core_vec_out in the cycle 8+k after that vector's phase 0. It is registered into out_data with out_valid = 1 one cycle later. Capture is enabled only for the 8 cycles following each vector's phase 7. The zero-vector result of DRAIN is never captured.
- No output backpressure; the downstream must accept every out_valid.

## Timing
- Reset: state IDLE, all counters 0, banks empty, w_loaded = 0, cfg_ready = 1, in_ready = 1, out_valid = 0, out_data = 0, out_last = 0, busy = 0, core_en = 0, core_vec = 0, core_w = 0.
- Phase 0 at cycle t0 → column k on out_data at t0+9+k; out_last at t0+16.
- Back-to-back: one vector per 8 cycles; output stream contiguous, 8 out_valid per vector.
- Single vector: 16 busy cycles, then at least one cycle in IDLE.
- Simultaneous 8th in_valid beat and phase-7 release of the same bank: the release takes effect first, so the fill goes to the freed bank correctly (no overwrite of the running bank).
- Reset mid-run or mid-load: everything is cleared, and partial vectors and weights are discarded.

## Structure
- Package tt_mult_pkg holds IN_LEN, OUT_LEN, BIT_WIDTH, CFG_W, derived constants (PAIRS = 8, W_BEATS = 32), and the state enum.
- Sub-module tt_mult_vec_buf is the two-bank ping-pong buffer (fill/run pointers, full flags, release). The FSM, weight shifter and capture logic live in tt_mult_ctrl.

## Test plan
- Load 32 beats of 0x55 (all +1); feed 8 pairs of 0x0101 → out_data = 0x10 ×8, out_last on the 8th beat, first out_valid 9 cycles after phase 0.
- Weights all 0xFF (-1), inputs all 0x01 → 0xF0 ×8. Inputs all 0x10 with +1 weights → 0x00 (wrap).
- Two full vectors queued (+1 weights, elements 1 then 2) → 16 contiguous out_valid, 0x10 ×8 then 0x20 ×8, no DRAIN between them.
- Start a weight load with 10 beats only, then fill a bank → no run starts, w_loaded = 0. Finish the remaining 22 beats → run starts.
- Assert rst during FEED phase 4 → all outputs reach reset values the same cycle. A fresh load plus a vector afterwards gives correct results.
- in_valid held high continuously while running → in_ready drops when both banks are full, and exactly 8 pairs are accepted per vector.

Source files
------------

// File: rtl/tt_mult_pkg.sv
// Shared constants and state type for the ternary multiply sequencer.
// Widths here are fixed by the multiply core this block drives.
package tt_mult_pkg;

  localparam int IN_LEN    = 16;
  localparam int OUT_LEN   = 8;
  localparam int BIT_WIDTH = 8;
  localparam int CFG_W     = 8;

  localparam int PAIRS   = IN_LEN / 2;
  localparam int PAIR_W  = 2 * BIT_WIDTH;
  localparam int PTR_W   = $clog2(PAIRS);
  localparam int W_BITS  = 2 * IN_LEN * OUT_LEN;
  localparam int W_BEATS = W_BITS / CFG_W;
  localparam int BEAT_W  = $clog2(W_BEATS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_FEED,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/tt_mult_vec_buf.sv
// Two-bank ping-pong store for input vectors: one bank fills from the pins
// while the other is read by the sequencer, banks are used strictly in turn.
module tt_mult_vec_buf
  import tt_mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [PAIR_W-1:0] wr_data,
  input  logic [PTR_W-1:0]  rd_phase,
  input  logic              rel,
  output logic [PAIR_W-1:0] rd_data,
  output logic              fill_free,
  output logic              run_full,
  output logic              next_full
);

  logic [PAIR_W-1:0] mem [2][PAIRS];
  logic              fill_bank;
  logic              run_bank;
  logic [PTR_W-1:0]  fill_ptr;
  logic [1:0]        full;
  logic              fill_done;
  logic [1:0]        rel_mask;
  logic [1:0]        set_mask;

  assign fill_done = wr_en && (fill_ptr == PTR_W'(PAIRS - 1));
  assign rel_mask  = rel ? (2'b01 << run_bank) : 2'b00;
  assign set_mask  = fill_done ? (2'b01 << fill_bank) : 2'b00;

  assign fill_free = !full[fill_bank];
  assign run_full  = full[run_bank];
  assign next_full = full[~run_bank];
  assign rd_data   = mem[run_bank][rd_phase];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[fill_bank][fill_ptr] <= wr_data;
    end
  end

  // Release clears before the fill sets, so a same-cycle release never
  // masks a bank that has just completed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_bank <= 1'b0;
      run_bank  <= 1'b0;
      fill_ptr  <= '0;
      full      <= '0;
    end else begin
      full <= (full & ~rel_mask) | set_mask;
      if (wr_en) begin
        fill_ptr <= fill_done ? '0 : fill_ptr + 1'b1;
        if (fill_done) begin
          fill_bank <= ~fill_bank;
        end
      end
      if (rel) begin
        run_bank <= ~run_bank;
      end
    end
  end

endmodule

// File: rtl/tt_mult_ctrl.sv
// Sequencer for the ternary matrix-vector core: byte-serial weight load,
// 8-cycle vector feed with zero-vector drain, and column result capture.
module tt_mult_ctrl
  import tt_mult_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  input  logic [CFG_W-1:0]     cfg_data,
  output logic                 cfg_ready,
  input  logic                 in_valid,
  input  logic [PAIR_W-1:0]    in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [BIT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 w_loaded,
  output logic                 busy,
  output logic                 core_en,
  output logic [PAIR_W-1:0]    core_vec,
  output logic [W_BITS-1:0]    core_w,
  input  logic [BIT_WIDTH-1:0] core_vec_out
);

  state_t            state;
  state_t            state_nxt;
  logic [PTR_W-1:0]  phase;
  logic [PTR_W-1:0]  phase_nxt;
  logic [BEAT_W-1:0] beat_cnt;
  logic [PTR_W-1:0]  cap_cnt;
  logic              cap_active;
  logic              cfg_fire;
  logic              last_phase;
  logic              rel;
  logic              run_full;
  logic              next_full;
  logic [PAIR_W-1:0] rd_data;

  tt_mult_vec_buf u_vec_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (in_valid && in_ready),
    .wr_data   (in_data),
    .rd_phase  (phase),
    .rel       (rel),
    .rd_data   (rd_data),
    .fill_free (in_ready),
    .run_full  (run_full),
    .next_full (next_full)
  );

  assign cfg_ready  = (state == ST_IDLE) || (state == ST_LOAD_W);
  assign busy       = (state == ST_FEED) || (state == ST_DRAIN);
  assign core_en    = busy;
  assign core_vec   = (state == ST_FEED) ? rd_data : '0;
  assign cfg_fire   = cfg_valid && cfg_ready;
  assign last_phase = (phase == PTR_W'(PAIRS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      phase <= '0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
    end
  end

  // The phase counter wraps naturally, so back-to-back vectors and the
  // drain both restart from phase 0 without an explicit clear.
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    rel       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cfg_fire) begin
          state_nxt = ST_LOAD_W;
        end else if (w_loaded && run_full && (beat_cnt == '0)) begin
          state_nxt = ST_FEED;
          phase_nxt = '0;
        end
      end
      ST_LOAD_W: begin
        if (cfg_fire && (beat_cnt == BEAT_W'(W_BEATS - 1))) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_FEED: begin
        phase_nxt = phase + 1'b1;
        if (last_phase) begin
          rel = 1'b1;
          if (!next_full) begin
            state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        phase_nxt = phase + 1'b1;
        if (last_phase) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Beats shift in from the top so beat n ends up at bits [n*8 +: 8].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      w_loaded <= 1'b0;
      core_w   <= '0;
    end else if (cfg_fire) begin
      core_w   <= {cfg_data, core_w[W_BITS-1:CFG_W]};
      beat_cnt <= beat_cnt + 1'b1;
      if (beat_cnt == '0) begin
        w_loaded <= 1'b0;
      end
      if (beat_cnt == BEAT_W'(W_BEATS - 1)) begin
        w_loaded <= 1'b1;
      end
    end
  end

  // The window opens after each fed vector's last phase; a drain never
  // opens one, so its zero-vector result is skipped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_active <= 1'b0;
      cap_cnt    <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
    end else begin
      cap_active <= ((state == ST_FEED) && last_phase)
                    || (cap_active && (cap_cnt != PTR_W'(PAIRS - 1)));
      cap_cnt    <= cap_active ? cap_cnt + 1'b1 : '0;
      out_valid  <= cap_active;
      out_last   <= cap_active && (cap_cnt == PTR_W'(PAIRS - 1));
      if (cap_active) begin
        out_data <= core_vec_out;
      end
    end
  end

endmodule

// File: tb/tb_tt_mult_ctrl.sv
// Self-checking bench for tt_mult_ctrl: emulates the multiply core and
// scores the output stream against an integer reference of the math.
module tb_tt_mult_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_valid;
  logic [7:0]   cfg_data;
  logic         cfg_ready;
  logic         in_valid;
  logic [15:0]  in_data;
  logic         in_ready;
  logic         out_valid;
  logic [7:0]   out_data;
  logic         out_last;
  logic         w_loaded;
  logic         busy;
  logic         core_en;
  logic [15:0]  core_vec;
  logic [255:0] core_w;
  logic [7:0]   core_vec_out;

  tt_mult_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_data     (cfg_data),
    .cfg_ready    (cfg_ready),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_last     (out_last),
    .w_loaded     (w_loaded),
    .busy         (busy),
    .core_en      (core_en),
    .core_vec     (core_vec),
    .core_w       (core_w),
    .core_vec_out (core_vec_out)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;
  int nOut    = 0;
  int cyc     = 0;

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- core emulator ----------------
  // Collects 8 pairs while enabled, then presents column k k cycles later.
  logic [127:0] core_acc = '0;
  logic [63:0]  core_res = '0;
  logic [7:0]   noise    = '0;
  int           core_cnt = 0;
  int           core_idx = 8;

  function automatic logic [63:0] coreCompute(input logic [127:0] v, input logic [255:0] w);
    logic [63:0] res;
    res = '0;
    for (int c = 0; c < 8; c++) begin
      logic [7:0] acc;
      acc = '0;
      for (int r = 0; r < 16; r++) begin
        logic [7:0] e;
        logic [1:0] code;
        e    = v[(r / 2) * 16 + ((r % 2 == 0) ? 8 : 0) +: 8];
        code = w[2 * (r * 8 + c) +: 2];
        if (code == 2'b01) acc = acc + e;
        else if (code[1]) acc = acc - e;
      end
      res[c * 8 +: 8] = acc;
    end
    return res;
  endfunction

  always @(posedge clk) begin
    noise <= 8'($urandom);
    if (core_en) begin
      core_acc <= {core_vec, core_acc[127:16]};
      if (core_cnt == 7) begin
        core_res <= coreCompute({core_vec, core_acc[127:16]}, core_w);
        core_cnt <= 0;
        core_idx <= 0;
      end else begin
        core_cnt <= core_cnt + 1;
        if (core_idx < 8) core_idx <= core_idx + 1;
      end
    end else begin
      core_cnt <= 0;
      if (core_idx < 8) core_idx <= core_idx + 1;
    end
  end

  assign core_vec_out = (core_idx < 8) ? 8'(core_res >> (8 * core_idx)) : noise;

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t         expq[$];
  exp_t         mexp;
  int           wt  [16][8];
  int           vec [16];
  logic [255:0] wimg;
  bit           sawStall;

  task automatic expectVector();
    for (int c = 0; c < 8; c++) begin
      int   s;
      exp_t e;
      s = 0;
      for (int r = 0; r < 16; r++) s += vec[r] * wt[r][c];
      e.data = 8'(s);
      e.last = (c == 7);
      expq.push_back(e);
    end
  endtask

  task automatic buildImage(input bit randNeg);
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 8; c++) begin
        logic [1:0] code;
        if (wt[r][c] == 1) code = 2'b01;
        else if (wt[r][c] == -1) code = (randNeg && $urandom_range(0, 1) == 1) ? 2'b10 : 2'b11;
        else code = 2'b00;
        wimg[2 * (r * 8 + c) +: 2] = code;
      end
    end
  endtask

  task automatic setWeights(input int v);
    for (int r = 0; r < 16; r++) for (int c = 0; c < 8; c++) wt[r][c] = v;
  endtask

  task automatic randomWeights();
    for (int r = 0; r < 16; r++) for (int c = 0; c < 8; c++) wt[r][c] = int'($urandom_range(0, 2)) - 1;
  endtask

  task automatic setVec(input int v);
    for (int r = 0; r < 16; r++) vec[r] = v;
  endtask

  task automatic randomVec();
    for (int r = 0; r < 16; r++) vec[r] = int'($urandom_range(0, 255)) - 128;
  endtask

  // ---------------- stimulus ----------------
  task automatic applyStimulus(input int lo, input int hi);
    for (int n = lo; n <= hi; n++) begin
      int g;
      g = 0;
      @(negedge clk);
      while (!cfg_ready && g < 500) begin
        cfg_valid = 1'b0;
        @(negedge clk);
        g++;
      end
      if (g >= 500) checkOutput("cfg_ready wait", 1'b0, 1'b1);
      cfg_valid = 1'b1;
      cfg_data  = wimg[n * 8 +: 8];
    end
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic pushVector(input bit hold);
    expectVector();
    for (int p = 0; p < 8; p++) begin
      int          g;
      logic [15:0] pair;
      pair = {8'(vec[2 * p]), 8'(vec[2 * p + 1])};
      g = 0;
      @(negedge clk);
      while (!in_ready && g < 500) begin
        sawStall = 1'b1;
        in_valid = hold;
        in_data  = pair;
        @(negedge clk);
        g++;
      end
      if (g >= 500) checkOutput("in_ready wait", 1'b0, 1'b1);
      in_valid = 1'b1;
      in_data  = pair;
    end
  endtask

  task automatic endInput();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic waitDone();
    int g;
    g = 0;
    @(negedge clk);
    while ((busy || expq.size() != 0) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 3000) checkOutput("drain wait", 1'b0, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic checkResetValues();
    checkOutput("rst cfg_ready", cfg_ready, 1'b1);
    checkOutput("rst in_ready", in_ready, 1'b1);
    checkOutput("rst out_valid", out_valid, 1'b0);
    checkOutput("rst out_data", out_data, 8'h00);
    checkOutput("rst out_last", out_last, 1'b0);
    checkOutput("rst w_loaded", w_loaded, 1'b0);
    checkOutput("rst busy", busy, 1'b0);
    checkOutput("rst core_en", core_en, 1'b0);
    checkOutput("rst core_vec", core_vec, 16'h0000);
    checkOutput("rst core_w", core_w, 256'h0);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (expq.size() == 0) begin
        checkOutput("unexpected out_valid", 1'b1, 1'b0);
      end else begin
        mexp = expq.pop_front();
        checkOutput("out_data", out_data, mexp.data);
        checkOutput("out_last", out_last, mexp.last);
      end
      nOut++;
    end
  end

  logic prevEn = 1'b0, prevOv = 1'b0, prevBusy = 1'b0;
  int   tPhase0 = 0, latFirst = 0, latLast = 0;
  int   busyCnt = 0, busyLen = 0, busyRises = 0, ovRun = 0, ovLen = 0;

  always @(negedge clk) begin
    if (core_en && !prevEn) tPhase0 <= cyc;
    if (out_valid && !prevOv) latFirst <= cyc - tPhase0;
    if (out_last) latLast <= cyc - tPhase0;
    busyCnt <= busy ? busyCnt + 1 : 0;
    if (!busy && prevBusy) busyLen <= busyCnt;
    if (busy && !prevBusy) busyRises <= busyRises + 1;
    ovRun <= out_valid ? ovRun + 1 : 0;
    if (!out_valid && prevOv) ovLen <= ovRun;
    prevEn   <= core_en;
    prevOv   <= out_valid;
    prevBusy <= busy;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    int rises0;
    int out0;
    int g;
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    sawStall  = 1'b0;
    wimg      = '0;
    repeat (3) @(negedge clk);
    checkResetValues();
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] all +1 weights, unit vector elements");
    setWeights(1);
    buildImage(1'b0);
    applyStimulus(0, 31);
    checkOutput("w_loaded after load", w_loaded, 1'b1);
    checkOutput("core_w all +1", core_w, {32{8'h55}});
    setVec(1);
    pushVector(1'b0);
    endInput();
    waitDone();
    checkOutput("sum of ones", out_data, 8'h10);
    checkOutput("first out latency", latFirst, 9);
    checkOutput("out_last latency", latLast, 16);
    checkOutput("single busy length", busyLen, 16);

    $display("[TB] all -1 weights and wrap-around");
    setWeights(-1);
    buildImage(1'b0);
    applyStimulus(0, 31);
    checkOutput("core_w all -1", core_w, {32{8'hFF}});
    setVec(1);
    pushVector(1'b0);
    endInput();
    waitDone();
    checkOutput("negative sum", out_data, 8'hF0);
    setWeights(1);
    buildImage(1'b0);
    applyStimulus(0, 31);
    setVec(16);
    pushVector(1'b0);
    endInput();
    waitDone();
    checkOutput("wrapped sum", out_data, 8'h00);

    $display("[TB] back-to-back vectors");
    setVec(1);
    pushVector(1'b0);
    setVec(2);
    pushVector(1'b0);
    endInput();
    waitDone();
    checkOutput("second vector sum", out_data, 8'h20);
    checkOutput("contiguous out_valid", ovLen, 16);
    checkOutput("back-to-back busy length", busyLen, 24);

    $display("[TB] partial weight load blocks the run");
    randomWeights();
    buildImage(1'b1);
    applyStimulus(0, 9);
    checkOutput("w_loaded partial", w_loaded, 1'b0);
    rises0 = busyRises;
    randomVec();
    pushVector(1'b0);
    endInput();
    repeat (30) @(negedge clk);
    checkOutput("no run while loading", busyRises, rises0);
    checkOutput("busy while loading", busy, 1'b0);
    applyStimulus(10, 31);
    checkOutput("w_loaded completed", w_loaded, 1'b1);
    checkOutput("core_w random image", core_w, wimg);
    waitDone();
    checkOutput("run after load", busyRises, rises0 + 1);

    $display("[TB] reset in the middle of a run");
    randomVec();
    pushVector(1'b0);
    endInput();
    g = 0;
    while (!core_en && g < 100) begin
      @(negedge clk);
      g++;
    end
    checkOutput("run start", core_en, 1'b1);
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1 checkResetValues();
    expq.delete();
    @(negedge clk);
    rst = 1'b0;
    randomWeights();
    buildImage(1'b1);
    applyStimulus(0, 31);
    randomVec();
    pushVector(1'b0);
    endInput();
    waitDone();

    $display("[TB] in_valid held high across a run");
    randomWeights();
    buildImage(1'b1);
    applyStimulus(0, 31);
    sawStall = 1'b0;
    out0 = nOut;
    for (int v = 0; v < 3; v++) begin
      randomVec();
      pushVector(1'b1);
    end
    endInput();
    waitDone();
    checkOutput("in_ready dropped", sawStall, 1'b1);
    checkOutput("beats for three vectors", nOut - out0, 24);

    $display("[TB] randomized rounds");
    for (int it = 0; it < 4; it++) begin
      int nv;
      randomWeights();
      buildImage(1'b1);
      applyStimulus(0, 31);
      checkOutput("core_w round image", core_w, wimg);
      nv = $urandom_range(1, 3);
      for (int v = 0; v < nv; v++) begin
        randomVec();
        pushVector(1'($urandom_range(0, 1)));
      end
      endInput();
      waitDone();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
    $finish;
  end

endmodule
